// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the backing
// memory. The arbiter takes the slave view; the environment (caches and
// memory model) takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
);
  localparam int BEAT_W = $clog2(BEATS);

  // instruction-cache refill port (read only)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  // data-cache port (read or write line bursts)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_wnext;
  logic              d_done;

  // beat index of the active burst
  logic [BEAT_W-1:0] beat;

  // backing-memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_gnt, i_rvalid, i_rdata, i_done,
    output d_gnt, d_rvalid, d_rdata, d_wnext, d_done,
    output beat, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_gnt, i_rvalid, i_rdata, i_done,
    input  d_gnt, d_rvalid, d_rdata, d_wnext, d_done,
    input  beat, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester line-burst arbiter: an instruction-cache refill port and a
// data-cache read/write port share one backing memory. Ties are broken in
// favour of whoever did not own the previous burst. Each burst moves BEATS
// words at consecutive word addresses inside one aligned line, then spends
// one DONE cycle pulsing the owner's done before arbitration reopens.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = ADDR_W - BEAT_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [BEAT_W-1:0]  beat_r, beat_s;
  logic               owner_r, owner_s;
  logic               last_owner_r, last_owner_s;
  logic [LINE_W-1:0]  line_r, line_s;
  logic               we_r, we_s;
  logic               pick_d_s;
  logic               beat_done_s;
  logic               in_burst_s;
  logic               in_done_s;
  logic               active_s;

  // State registers; reset aborts any burst and makes D win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      beat_r       <= {BEAT_W{1'b0}};
      owner_r      <= OWN_I;
      last_owner_r <= OWN_I;
      line_r       <= {LINE_W{1'b0}};
      we_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      line_r       <= line_s;
      we_r         <= we_s;
    end
  end

  // Arbitration choice: a lone requester wins, a tie goes to the non-last owner.
  always_comb begin
    pick_d_s = 1'b0;
    if (bus.i_req && bus.d_req) begin
      pick_d_s = (last_owner_r == OWN_I);
    end else if (bus.d_req) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Next-state logic: latch owner/line/write flag on grant, step beats on ready.
  always_comb begin
    state_s      = state_r;
    beat_s       = beat_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    line_s       = line_r;
    we_s         = we_r;
    case (state_r)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_s      = pick_d_s ? OWN_D : OWN_I;
          last_owner_s = pick_d_s ? OWN_D : OWN_I;
          line_s       = pick_d_s ? bus.d_addr[ADDR_W-1:BEAT_W+2]
                                  : bus.i_addr[ADDR_W-1:BEAT_W+2];
          we_s         = pick_d_s ? bus.d_we : 1'b0;
          beat_s       = {BEAT_W{1'b0}};
          state_s      = BURST;
        end else begin
          state_s      = IDLE;
        end
      end
      BURST: begin
        // the last beat parks the counter; DONE follows with no extra beat
        if (beat_done_s) begin
          if (beat_r == LAST_BEAT) begin
            state_s = DONE;
          end else begin
            beat_s  = beat_r + BEAT_W'(1'b1);
          end
        end else begin
          state_s = BURST;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign in_burst_s  = (state_r == BURST);
  assign in_done_s   = (state_r == DONE);
  assign active_s    = in_burst_s || in_done_s;
  assign beat_done_s = in_burst_s && bus.mem_ready;

  // Grants and done pulses decode straight from registered state.
  assign bus.i_gnt    = active_s && (owner_r == OWN_I);
  assign bus.d_gnt    = active_s && (owner_r == OWN_D);
  assign bus.i_done   = in_done_s && (owner_r == OWN_I);
  assign bus.d_done   = in_done_s && (owner_r == OWN_D);

  // Beat strobes follow the memory handshake in the same cycle.
  assign bus.i_rvalid = beat_done_s && (owner_r == OWN_I);
  assign bus.d_rvalid = beat_done_s && (owner_r == OWN_D) && !we_r;
  assign bus.d_wnext  = beat_done_s && (owner_r == OWN_D) && we_r;
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

  // Memory port: line-aligned address with the beat index as word offset.
  assign bus.beat      = beat_r;
  assign bus.mem_req   = in_burst_s;
  assign bus.mem_we    = in_burst_s && we_r;
  assign bus.mem_addr  = {line_r, beat_r, 2'b00};
  assign bus.mem_wdata = bus.d_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: all inputs change on the falling
// edge, outputs are compared 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) bus();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // all single-bit handshake outputs packed: i_gnt,i_rvalid,i_done,d_gnt,d_rvalid,d_wnext,d_done,mem_req,mem_we
  function automatic logic [8:0] flags();
    return {bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_gnt, bus.d_rvalid,
            bus.d_wnext, bus.d_done, bus.mem_req, bus.mem_we};
  endfunction

  initial begin
    int exp_beat;
    int n;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.i_req = 1'b0;      bus.i_addr = 32'h0;
    bus.d_req = 1'b0;      bus.d_we = 1'b0;
    bus.d_addr = 32'h0;    bus.d_wdata = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;

    // ---- reset state
    cyc(); cyc();
    #1;
    chk("rst_flags", 64'(flags()), 64'h0);
    chk("rst_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_beat", 64'(bus.beat), 64'h0);

    // ---- single I refill at 0x104, memory always ready
    cyc(); reset = 1'b1;
    cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h104; bus.mem_ready = 1'b1; #1;
    chk("i_idle_flags", 64'(flags()), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(); bus.mem_rdata = 32'hA0 + 32'(k); #1;
      chk("i_beat_flags", 64'(flags()), 64'b1_1_0_0_0_0_0_1_0);
      chk("i_beat_addr", 64'(bus.mem_addr), 64'h100 + 64'(4 * k));
      chk("i_beat_idx", 64'(bus.beat), 64'(k));
      chk("i_rdata", 64'(bus.i_rdata), 64'hA0 + 64'(k));
    end
    cyc(); bus.i_req = 1'b0; #1;
    chk("i_done_flags", 64'(flags()), 64'b1_0_1_0_0_0_0_0_0);
    cyc(); #1;
    chk("i_back_idle", 64'(flags()), 64'h0);

    // ---- tie after reset: D first, I two cycles after d_done
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400; #1;
    chk("tie_idle", 64'(flags()), 64'h0);
    cyc(); #1;
    chk("tie_d_first", 64'(flags()), 64'b0_0_0_1_1_0_0_1_0);
    chk("tie_d_addr", 64'(bus.mem_addr), 64'h400);
    cyc(); cyc(); cyc();
    cyc(); bus.d_req = 1'b0; #1;
    chk("tie_d_done", 64'(flags()), 64'b0_0_0_1_0_0_1_0_0);
    cyc(); #1;
    chk("tie_gap", 64'(flags()), 64'h0);
    cyc(); #1;
    chk("tie_i_next", 64'(flags()), 64'b1_1_0_0_0_0_0_1_0);
    chk("tie_i_addr", 64'(bus.mem_addr), 64'h300);
    cyc(); cyc(); cyc();
    cyc(); bus.i_req = 1'b0; #1;
    chk("tie_i_done", 64'(bus.i_done), 64'h1);

    // ---- both held: D, I, D, I
    for (int b = 0; b < 4; b++) begin
      cyc(); bus.i_req = 1'b1; bus.d_req = 1'b1; #1;
      chk("alt_idle", 64'({bus.i_gnt, bus.d_gnt}), 64'h0);
      cyc(); #1;
      chk("alt_owner", 64'({bus.i_gnt, bus.d_gnt}), (b % 2 == 0) ? 64'b01 : 64'b10);
      cyc(); cyc(); cyc();
      cyc(); #1;
      chk("alt_done", 64'({bus.i_done, bus.d_done}), (b % 2 == 0) ? 64'b01 : 64'b10);
    end
    cyc(); bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
    chk("alt_end", 64'(flags()), 64'h0);

    // ---- D write at 0x2000 with memory ready every other cycle
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.mem_ready = 1'b0; #1;
    chk("wr_idle", 64'(flags()), 64'h0);
    exp_beat = 0;
    n = 0;
    while (exp_beat < 4 && n < 20) begin
      cyc(); bus.mem_ready = n[0]; bus.d_wdata = 32'hD000 + 32'(exp_beat); #1;
      chk("wr_flags", 64'(flags()), {55'h0, 2'b00, 1'b0, 1'b1, 1'b0, n[0], 1'b0, 2'b11});
      chk("wr_addr", 64'(bus.mem_addr), 64'h2000 + 64'(4 * exp_beat));
      chk("wr_beat", 64'(bus.beat), 64'(exp_beat));
      chk("wr_wdata", 64'(bus.mem_wdata), 64'hD000 + 64'(exp_beat));
      if (n[0]) exp_beat++;
      n++;
    end
    chk("wr_bound", 64'(exp_beat), 64'd4);
    cyc(); bus.mem_ready = 1'b1; bus.d_req = 1'b0; #1;
    chk("wr_done", 64'(flags()), 64'b0_0_0_1_0_0_1_0_0);
    cyc(); #1;
    chk("wr_idle_ready", 64'(flags()), 64'h0);

    // ---- reset on beat 2 of a D read
    cyc(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    cyc(); cyc();
    cyc(); #1;
    chk("rb_beat2", 64'(bus.beat), 64'd2);
    reset = 1'b0; #1;
    chk("rb_flags", 64'(flags()), 64'h0);
    chk("rb_addr", 64'(bus.mem_addr), 64'h0);
    cyc(); reset = 1'b1; bus.d_req = 1'b0; #1;
    chk("rb_no_done0", 64'(flags()), 64'h0);
    cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h600; #1;
    chk("rb_no_done1", 64'(bus.d_done), 64'h0);
    cyc(); #1;
    chk("rb_i_gnt", 64'(flags()), 64'b1_1_0_0_0_0_0_1_0);
    chk("rb_i_addr", 64'(bus.mem_addr), 64'h600);
    cyc(); cyc(); cyc();
    cyc(); bus.i_req = 1'b0; #1;
    chk("rb_i_done", 64'(flags()), 64'b1_0_1_0_0_0_0_0_0);

    // ---- d_req dropped after beat 1 still finishes the burst
    cyc(); bus.d_req = 1'b1; bus.d_addr = 32'h70C;
    cyc(); #1;
    chk("drop_b0_addr", 64'(bus.mem_addr), 64'h700);
    cyc(); #1;
    chk("drop_b1", 64'(bus.beat), 64'd1);
    cyc(); bus.d_req = 1'b0; #1;
    chk("drop_b2", 64'({bus.d_gnt, bus.beat}), {61'h0, 1'b1, 2'd2});
    cyc(); #1;
    chk("drop_b3_addr", 64'(bus.mem_addr), 64'h70C);
    cyc(); #1;
    chk("drop_done", 64'(flags()), 64'b0_0_0_1_0_0_1_0_0);
    cyc(); #1;
    chk("drop_once", 64'(flags()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002: Parameter DATA_W, default 32, word width of all data ports.
REQ-003: Parameter BEATS, default 4, words per line burst; power of two, at least 2.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset.
REQ-006: i_req / i_addr  input  1 / ADDR_W  instruction-cache line-refill request and line address (read only).
REQ-007: i_gnt / i_rvalid / i_rdata / i_done  output  1 / 1 / DATA_W / 1  grant, read beat valid, beat data, burst-complete pulse.
REQ-008: d_req / d_we / d_addr / d_wdata  input  1 / 1 / ADDR_W / DATA_W  data-cache request, write flag, line address, current write beat.
REQ-009: d_gnt / d_rvalid / d_rdata / d_wnext / d_done  output  1 / 1 / DATA_W / 1 / 1  grant, read beat valid, beat data, write beat consumed, burst-complete pulse.
REQ-010: beat  output  log2(BEATS)  index of the current beat of the active burst.
REQ-011: mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_W / DATA_W  backing-memory port.
REQ-012: mem_rdata / mem_ready  input  DATA_W / 1  memory read data; the beat completes in any cycle where mem_req and mem_ready are both high.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, BURST, DONE.
REQ-014: IDLE with any req high SHALL latch the owner, the address, and for D the d_we flag, then go to BURST on the next edge. Beat counter SHALL be cleared to 0.
REQ-015: Arbitration when only one req is high SHALL grant that requester.
REQ-016: Arbitration when both reqs are high SHALL grant the requester that is not last_owner; last_owner SHALL update on every grant.
REQ-017: The owner's gnt SHALL be high throughout BURST and DONE; the non-owner's gnt SHALL be low.
REQ-018: Latency from req sampled in IDLE to gnt/mem_req high SHALL be one cycle.
REQ-019: In BURST, mem_req SHALL be high.
REQ-020: In BURST, mem_we SHALL equal the latched write flag, which is always 0 for the I owner.
REQ-021: mem_addr SHALL equal {latched_addr[ADDR_W-1 : log2(BEATS)+2], beat, 2'b00}; the latched address low bits SHALL be ignored (line aligned).
REQ-022: On each completed beat the counter SHALL increment. On completion of beat BEATS-1 the FSM SHALL go to DONE, with no wrap into a further beat.
REQ-023: Read burst: the owner's rvalid SHALL equal mem_req & mem_ready, and its rdata SHALL equal mem_rdata (combinational). The non-owner's rvalid SHALL be 0.
REQ-024: Write burst: mem_wdata SHALL equal d_wdata, and d_wnext SHALL equal mem_req & mem_ready; the D cache presents the next word after each d_wnext.
REQ-025: DONE SHALL last one cycle. In it the owner's done SHALL pulse high and mem_req SHALL be low; the FSM SHALL then return to IDLE.
REQ-026: The earliest next grant SHALL come two cycles after DONE (DONE -> IDLE arbitrate -> BURST).
REQ-027: Requesters SHALL hold req, addr and d_we stable until done. A req dropped mid-burst SHALL be ignored; the burst completes and done still pulses.
REQ-028: mem_ready low SHALL stall the beat with no limit; all outputs SHALL hold.
REQ-029: mem_ready while not in BURST SHALL have no effect.

Reset
REQ-030: While reset is low, state SHALL be IDLE, the beat counter 0, and last_owner I, so D wins the first tie.
REQ-031: While reset is low, all gnt, rvalid, wnext, done and mem_req/mem_we outputs SHALL be 0, and mem_addr 0.
REQ-032: Reset asserted mid-burst SHALL abort the burst immediately, with no done pulse; after reset release, arbitration restarts from IDLE.

Verification
REQ-033: Only i_req at addr 0x104, mem_ready always 1 -> i_gnt on next cycle; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; four i_rvalid; i_done one cycle later; total 6 cycles from req to IDLE.
REQ-034: i_req and d_req together after reset -> D granted first; after d_done, I is granted two cycles later.
REQ-035: Both reqs held continuously -> grants alternate D, I, D, I over four bursts.
REQ-036: D write at 0x2000, mem_ready low every other cycle -> mem_we 1; four d_wnext pulses aligned with mem_ready; mem_wdata tracks d_wdata; beat holds during stalls.
REQ-037: Reset asserted on beat 2 of a D read -> all outputs 0 immediately; no d_done; a new i_req is then served normally.
REQ-038: d_req dropped after beat 1 -> burst still finishes four beats and d_done pulses once.
